// File: rtl/rv32i_encoder.sv
// Streaming RV32I instruction encoder: packs instruction fields into a 32-bit word,
// checks immediate ranges, and queues words with their target address for instruction memory.
module rv32i_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               fmt,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [31:0]              imm,
    input  logic                     base_load,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    // True when v is representable as a two's-complement number of the given width.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic signed [31:0] sv;
        logic signed [31:0] hi;
        sv = v;
        hi = sv >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic                 w_is_shift;
    logic [31:0]          w_inst;
    logic                 w_err;
    logic                 w_push;
    logic                 w_pop;
    logic [ADDR_W-1:0]    w_entry_addr;

    logic [31:0]          r_mem_inst [DEPTH];
    logic [ADDR_W-1:0]    r_mem_addr [DEPTH];
    logic                 r_mem_err  [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [ADDR_W-1:0]    r_addr_cnt;
    logic [7:0]           r_err_count;

    assign w_is_shift = (opcode == 7'b0010011) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    always_comb begin
        w_inst = 32'h0000_0013;
        w_err  = 1'b0;
        case (fmt)
            3'd0: w_inst = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: begin
                if (w_is_shift) begin
                    w_inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    w_err  = |imm[31:5];
                end else begin
                    w_inst = {imm[11:0], rs1, funct3, rd, opcode};
                    w_err  = !fits_signed(imm, 12);
                end
            end
            3'd2: begin
                w_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_err  = !fits_signed(imm, 12);
            end
            3'd3: begin
                w_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_err  = imm[0] || !fits_signed(imm, 13);
            end
            3'd4: begin
                w_inst = {imm[31:12], rd, opcode};
                w_err  = |imm[11:0];
            end
            3'd5: begin
                w_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_err  = imm[0] || !fits_signed(imm, 21);
            end
            default: begin
                w_inst = 32'h0000_0013;
                w_err  = 1'b1;
            end
        endcase
    end

    assign in_ready     = (r_level < DEPTH_L);
    assign out_valid    = (r_level != '0);
    assign w_push       = in_valid && in_ready && !flush;
    assign w_pop        = out_valid && out_ready && !flush;
    assign w_entry_addr = base_load ? base_addr : r_addr_cnt;

    assign out_inst  = out_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign out_addr  = out_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign out_err   = out_valid ? r_mem_err[r_rd_ptr]  : 1'b0;
    assign level     = r_level;
    assign err_count = r_err_count;

    // Storage holds data only; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= w_inst;
            r_mem_addr[r_wr_ptr] <= w_entry_addr;
            r_mem_err[r_wr_ptr]  <= w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_addr_cnt  <= '0;
            r_err_count <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_W'(1);
                    2'b01:   r_level <= r_level - LVL_W'(1);
                    default: r_level <= r_level;
                endcase
            end

            // A loaded base applies to the word pushed in the same cycle.
            if (w_push)         r_addr_cnt <= w_entry_addr + ADDR_W'(1);
            else if (base_load) r_addr_cnt <= base_addr;

            if (w_push && w_err) r_err_count <= sat_inc(r_err_count);
        end
    end

endmodule

// File: tb/tb_rv32i_encoder.sv
// Bench for rv32i_encoder: fixed encoding table, FIFO/address corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_rv32i_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd, rs1, rs2;
    logic [31:0]       imm;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [2:0]        level;
    logic [7:0]        err_count;

    always #5 clk = ~clk;

    rv32i_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .base_load(base_load), .base_addr(base_addr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .level(level), .err_count(err_count)
    );

    typedef struct {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] addr;
        bit                err;
    } ent_t;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] inst;
        bit          err;
    } vec_t;

    ent_t              mq[$];
    logic [ADDR_W-1:0] m_cnt;
    int                m_errc;
    int                n_vec = 0;
    int                n_err = 0;
    vec_t              tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoder built from field positions with shifts/masks and signed range tests.
    function automatic void ref_enc(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                                    input logic [4:0] s2, input logic [31:0] im,
                                    output logic [31:0] w, output bit e);
        int s;
        logic [31:0] common;
        s = int'($signed(im));
        common = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
        case (f)
            3'd0: begin
                w = common | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
                e = 0;
            end
            3'd1: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w = common | (32'(d) << 7) | ((im % 32) << 20) | (32'(f7) << 25);
                    e = (im > 32'd31);
                end else begin
                    w = common | (32'(d) << 7) | ((im & 32'hFFF) << 20);
                    e = (s < -2048) || (s > 2047);
                end
            end
            3'd2: begin
                w = common | ((im & 32'd31) << 7) | (32'(s2) << 20) | (((im >> 5) & 32'd127) << 25);
                e = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = common | (((im >> 11) & 32'd1) << 7) | (((im >> 1) & 32'd15) << 8)
                    | (32'(s2) << 20) | (((im >> 5) & 32'd63) << 25) | (((im >> 12) & 32'd1) << 31);
                e = ((im % 2) != 0) || (s < -4096) || (s > 4095);
            end
            3'd4: begin
                w = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
                e = (im % 4096) != 0;
            end
            3'd5: begin
                w = 32'(op) | (32'(d) << 7) | (((im >> 12) & 32'd255) << 12) | (((im >> 11) & 32'd1) << 20)
                    | (((im >> 1) & 32'd1023) << 21) | (((im >> 20) & 32'd1) << 31);
                e = ((im % 2) != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
            end
            default: begin
                w = 32'h13;
                e = 1;
            end
        endcase
    endfunction

    task automatic compare();
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("level", level, mq.size());
        chk("out_valid", out_valid, mq.size() != 0);
        chk("err_count", err_count, m_errc);
        if (mq.size() != 0) begin
            chk("out_inst", out_inst, mq[0].inst);
            chk("out_addr", out_addr, mq[0].addr);
            chk("out_err", out_err, mq[0].err);
        end
    endtask

    // One clock: predict from the current inputs, cross the edge, then compare at negedge.
    task automatic tick();
        bit acc, pop, e;
        logic [31:0] w;
        ent_t en;
        acc = in_valid && (mq.size() < DEPTH);
        pop = (mq.size() != 0) && out_ready;
        ref_enc(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, w, e);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            if (base_load) m_cnt = base_addr;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                en.inst = w;
                en.err  = e;
                en.addr = base_load ? base_addr : m_cnt;
                mq.push_back(en);
                m_cnt = en.addr + 1'b1;
                if (e && m_errc < 255) m_errc++;
            end else if (base_load) begin
                m_cnt = base_addr;
            end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt  = '0;
        m_errc = 0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (mq.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_done", level, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3, 1'b0};
        tbl[1]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,  32'hFE208EE3, 1'b0};
        tbl[2]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4097,      32'h80208063, 1'b1};
        tbl[3]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b0};
        tbl[4]  = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0};
        tbl[5]  = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001,  32'h123452B7, 1'b1};
        tbl[6]  = '{3'd7, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0,         32'h00000013, 1'b1};
        tbl[7]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF,  32'hFFF10093, 1'b0};
        tbl[8]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd2048,      32'h80010093, 1'b1};
        tbl[9]  = '{3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3,         32'h40315093, 1'b0};
        tbl[10] = '{3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd32,        32'h40015093, 1'b1};
        tbl[11] = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b0};
        tbl[12] = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFF7FF,  32'h7E20AFA3, 1'b1};
        tbl[13] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3,         32'h0020006F, 1'b1};
        tbl[14] = '{3'd6, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0,         32'h00000013, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        base_load = 1'b0; base_addr = '0;
        set_fields(3'd0, 7'h33, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
        model_reset();
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_level", level, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Encoding table: one word per pass, checked at the cycle after acceptance.
        for (int i = 0; i < 15; i++) begin
            set_fields(tbl[i].fmt, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            in_valid  = 1'b1;
            base_load = (i == 0);
            base_addr = 10'h010;
            tick();
            in_valid  = 1'b0;
            base_load = 1'b0;
            chk($sformatf("tbl%0d_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_inst", i), out_inst, tbl[i].inst);
            chk($sformatf("tbl%0d_err", i), out_err, tbl[i].err);
            chk($sformatf("tbl%0d_addr", i), out_addr, 10'h010 + i);
            if (i == 2) chk("errcnt_after_B_odd", err_count, 1);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Backpressure: DEPTH+1 offered words with the sink stalled, then stream with pushes.
        set_fields(3'd0, 7'h33, 3'd0, 7'h00, 5'd0, 5'd4, 5'd5, 32'd0);
        in_valid = 1'b1;
        for (int k = 0; k <= DEPTH; k++) begin
            rd = 5'(k);
            tick();
        end
        chk("bp_level_full", level, DEPTH);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_head_rd0", out_inst, 32'h005200B3 & 32'hFFFFF07F);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd = 5'(10 + k);
            tick();
        end
        drain();

        // Address wrap, then flush against a concurrent push.
        in_valid = 1'b1; base_load = 1'b1; base_addr = 10'h3FF;
        tick();
        base_load = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("wrap_head_addr", out_addr, 10'h3FF);
        chk("wrap_level", level, 2);
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_out_valid", out_valid, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_flush_addr", out_addr, 10'h001);
        drain();
        in_valid = 1'b1; base_load = 1'b1; base_addr = 10'h3FF; out_ready = 1'b1;
        tick();
        base_load = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("wrap_second_addr", out_addr, 10'h000);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 6;
            flush     = ($urandom % 40) == 0;
            base_load = ($urandom % 25) == 0;
            base_addr = 10'($urandom);
            fmt    = 3'($urandom);
            opcode = (($urandom % 2) == 0) ? 7'h13 : 7'($urandom);
            funct3 = 3'($urandom);
            funct7 = 7'($urandom);
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            case ($urandom % 4)
                0: imm = $urandom;
                1: imm = $urandom_range(0, 63);
                2: imm = 32'(-int'($urandom_range(0, 5000)));
                default: imm = 32'(int'($urandom_range(0, 1 << 21)) - (1 << 20));
            endcase
            tick();
        end
        flush = 1'b0; base_load = 1'b0;
        drain();

        // Error counter saturation.
        set_fields(3'd7, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 300; n++) tick();
        chk("errcnt_saturated", err_count, 255);
        drain();

        // Asynchronous reset in the middle of a burst.
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_level", level, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_fields(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("after_rst_addr", out_addr, 0);
        chk("after_rst_inst", out_inst, 32'h402081B3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_encoder.md
Name: rv32i_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the core's field decoder. It takes instruction fields plus a full 32-bit immediate value and packs them into a legal 32-bit instruction word, performing the B/J/S bit-scrambling and immediate range checks. Encoded words are buffered in a FIFO, tagged with an auto-incrementing word address, and streamed to the instruction-memory write port. Used by the boot/program loader and by self-checking benches.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
ADDR_W, 10, word-address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  field set valid
in_ready  out  1  encoder can accept
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
opcode  in  7  opcode field
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R, I-shift)
rd, rs1, rs2  in  5 each  register indices
imm  in  32  immediate value (byte offset for B/J)
base_load  in  1  load address counter
base_addr  in  ADDR_W  new address
flush  in  1  synchronous FIFO clear
out_valid  out  1  word available
out_ready  in  1  memory accepts word
out_inst  out  32  encoded instruction
out_addr  out  ADDR_W  word address
out_err  out  1  this word had a range/format error
level  out  $clog2(DEPTH)+1  FIFO occupancy
err_count  out  8  saturating error count

Behaviour:
- Reset (async, rst_n=0): FIFO empty, level=0, out_valid=0, out_inst=0, out_addr=0, out_err=0, address counter=0, err_count=0. in_ready=1 after reset.
- Accept on in_valid&&in_ready. in_ready = (level<DEPTH). Encoding is combinational on inputs; the word is written into the FIFO on the accepting edge. Latency: accepted at edge N → out_valid=1 after edge N (visible in cycle N+1) when FIFO was empty. Output is FIFO head, held stable while out_valid&&!out_ready.
- Pop on out_valid&&out_ready. Push and pop in the same cycle: level unchanged, both happen (also legal when full, since pop frees a slot only at the next edge: in_ready stays 0 that cycle).
- Encoding:
  R: {funct7,rs2,rs1,funct3,rd,opcode}. No range check.
  I: {imm[11:0],rs1,funct3,rd,opcode}; error unless imm[31:11] all equal. I-shift (opcode 0010011, funct3 001/101): {funct7,imm[4:0],rs1,funct3,rd,opcode}; error unless imm in 0..31.
  S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; error unless imm[31:11] all equal.
  B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; error if imm[0]=1 or imm[31:12] not all equal.
  U: {imm[31:12],rd,opcode}; error if imm[11:0]≠0.
  J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; error if imm[0]=1 or imm[31:20] not all equal.
  fmt 6/7: word = 32'h00000013 (NOP), error=1.
- On error the truncated encoding is still written with err=1. err_count increments per accepted erroneous word and saturates at 255. err_count is cleared only by reset.
- Address: each entry stores the address counter value at push; the counter increments by 1 per push and wraps at 2^ADDR_W. base_load without push: counter=base_addr. base_load with push: the pushed entry gets base_addr and counter=base_addr+1. base_load does not alter queued entries.
- flush: FIFO empties next edge (level=0, out_valid=0), any same-cycle push is discarded, counter and err_count are kept. flush has priority over push/pop.
- Reset mid-stream discards everything immediately.

Test Plan:
- R encode: fmt=0, opcode=0110011, funct3=0, funct7=0100000, rd=3, rs1=1, rs2=2, base_load at 0x010 → out_inst=0x402081B3, out_addr=0x010, out_err=0, one cycle latency.
- B scramble: fmt=3, opcode=1100011, funct3=0, rs1=1, rs2=2, imm=-4 → 0xFE208EE3, err=0. Repeat with imm=4097 (odd) → err=1, err_count=1.
- J/U: fmt=5, opcode=1101111, rd=1, imm=2048 → 0x001000EF. fmt=4, opcode=0110111, rd=5, imm=0x12345000 → 0x123452B7. Same with imm=0x12345001 → err=1.
- Backpressure: out_ready=0, push DEPTH+1 words → in_ready drops after DEPTH words, level=DEPTH, head stable. Then out_ready=1 with simultaneous pushes → in-order addresses, no loss or duplication.
- Wrap/flush: base 2^ADDR_W−1, push 2 → addresses 0x3FF then 0x000. flush with 2 queued plus a concurrent push → level=0, next push gets counter value 0x001.
- Illegal fmt=7 → out_inst=0x00000013, err=1. Assert rst_n low mid-burst → out_valid=0 immediately, err_count=0.
